dvp_tx: RTL
===========

// Module: dvp_tx
// PURPOSE
//  DVP (OV-sensor style) byte-parallel video transmitter, the source end of the camera capture path.
//  Pulls RGB565 pixels over a valid/ready stream and emits vsync/href/8-bit data at one byte per clk.
//  Each pixel goes out high byte first, then low byte. Line/frame timing is fixed by parameters.
//  Used as a sensor emulator and loopback source for the capture/framebuffer path.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line (2*H_ACTIVE byte cycles with href=1)
//  H_BLANK    144  href-low cycles per line
//  V_ACTIVE   480  active lines per frame
//  VS_LINES   3    lines with vsync asserted
//  VBP_LINES  17   blank lines after vsync, before first active line
//  VFP_LINES  10   blank lines after last active line
//  VS_POL     1    vsync active level (1 = active-high)
// PORTS
//  clk           in   1   single clock; byte rate; the only clock
//  rst           in   1   synchronous, active-high reset
//  enable        in   1   start/continue frames; sampled only at a frame boundary
//  pix_data      in   16  RGB565 pixel
//  pix_valid     in   1   pix_data valid
//  pix_ready     out  1   pixel accepted on a cycle where pix_valid & pix_ready
//  dvp_vsync     out  1   frame sync, polarity per VS_POL
//  dvp_href      out  1   byte valid / line active
//  dvp_db        out  8   data byte
//  frame_done    out  1   one-cycle pulse on the last cycle of the VFP period
//  underflow     out  1   sticky: an active pixel slot had no valid pixel
// BEHAVIOUR
//  Definitions: LINE_TOT = 2*H_ACTIVE+H_BLANK cycles; h_cnt 0..LINE_TOT-1 wraps and increments v_cnt.
//  Reset: state=IDLE, h_cnt=v_cnt=0, dvp_vsync=!VS_POL, dvp_href=0, dvp_db=0, pix_ready=0,
//    frame_done=0, underflow=0. Reset asserted mid-frame aborts on the next edge; no partial-line completion.
//  FSM (all DVP outputs registered):
//   IDLE  : outputs inactive. enable=1 -> VSYNC next cycle with h_cnt=0.
//   VSYNC : dvp_vsync=VS_POL for VS_LINES*LINE_TOT cycles -> VBP.
//   VBP   : VBP_LINES*LINE_TOT cycles -> ACTIVE.
//   ACTIVE: V_ACTIVE lines. h_cnt<2*H_ACTIVE: href=1. Even h_cnt: db=pix[15:8]. Odd h_cnt: db=pix[7:0].
//           h_cnt>=2*H_ACTIVE: href=0, db=0. Last line done -> VFP.
//   VFP   : VFP_LINES*LINE_TOT cycles. frame_done on final cycle. Then enable=1 -> VSYNC, else IDLE.
//  Stream: pix_ready=1 exactly on the cycle before each even active byte (one cycle per pixel).
//    A pixel accepted at cycle t is db high at t+1 and low at t+2. pix_ready never depends on pix_valid.
//  Underflow: pix_ready=1 & pix_valid=0 -> that pixel is sent as 0x00,0x00 and underflow is set.
//    Timing never stalls. underflow is cleared only by rst or by the IDLE->VSYNC transition.
//  enable deasserted mid-frame: the current frame completes and the FSM then enters IDLE.
//  A zero-length count (VS/VBP/VFP_LINES=0) skips that state in zero cycles.
//  Counters are sized $clog2(max+1). No arithmetic overflow is possible within legal params.
// STRUCTURE
//  dvp_tx_pkg: state enum (IDLE,VSYNC,VBP,ACTIVE,VFP) and LINE_TOT/width helper functions.
//  Sub-module dvp_timing_gen: h/v counters, state, and end-of-line/end-of-period strobes.
//  The top holds the byte mux, pixel latch and underflow flag.
// TESTING (H_ACTIVE=4,H_BLANK=3,V_ACTIVE=2,VS_LINES=1,VBP_LINES=1,VFP_LINES=1; LINE_TOT=11, frame=55)
//  1 Reset/idle: rst 3 cycles, enable=0 for 20 cycles.
//    -> vsync=0, href=0, db=0, pix_ready=0 throughout.
//  2 Full frame: enable=1, pixels 0x1234,0xABCD,... always valid.
//    -> vsync high cycles 1..11; first href at cycle 23; db sequence 12,34,AB,CD,...
//    -> 8 href cycles per line; frame_done at cycle 55; 8 pixels consumed.
//  3 Underflow: drop pix_valid for the 3rd pixel.
//    -> db 00,00 in that slot; underflow=1 stays set through frame end.
//    -> Next frame starts at the same cycle as with no underflow.
//  4 Back-to-back: enable held.
//    -> vsync re-asserts on the cycle after frame_done; underflow cleared only after IDLE.
//  5 Stop: drop enable at line 1 of ACTIVE.
//    -> frame finishes (frame_done fires), then IDLE, no new vsync.
//  6 Reset mid-line: assert rst with href=1.
//    -> next cycle all outputs at reset values; restart gives an identical frame.

Source files
------------

// File: rtl/dvp_tx_pkg.sv
// Shared types and sizing helpers for the DVP byte-parallel video transmitter.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } dvp_state_e;

  function automatic int line_tot(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Line/frame timing for the DVP transmitter: h/v counters, frame state and
// look-ahead (next-cycle) values so the top can register its outputs aligned.
module dvp_timing_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 144,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  localparam int LINE_TOT = line_tot(H_ACTIVE, H_BLANK),
  localparam int H_W      = cnt_w(LINE_TOT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output dvp_state_e       state_q,
  output dvp_state_e       state_d,
  output logic [H_W-1:0]   h_d,
  output logic             frame_last_d
);

  localparam int V_W = cnt_w(max4(VS_LINES, VBP_LINES, V_ACTIVE, VFP_LINES));
  localparam logic [H_W-1:0] H_LAST = H_W'(LINE_TOT - 1);
  localparam dvp_state_e LAST_ST = (VFP_LINES > 0) ? ST_VFP : ST_ACTIVE;

  logic [H_W-1:0] h_q;
  logic [V_W-1:0] v_q, v_d;
  logic           eol, eop;

  function automatic int lines_of(input dvp_state_e s);
    case (s)
      ST_VSYNC:  return VS_LINES;
      ST_VBP:    return VBP_LINES;
      ST_ACTIVE: return V_ACTIVE;
      ST_VFP:    return VFP_LINES;
      default:   return 0;
    endcase
  endfunction

  // Zero-length periods are skipped so they cost no cycles.
  function automatic dvp_state_e first_state();
    if (VS_LINES > 0) return ST_VSYNC;
    if (VBP_LINES > 0) return ST_VBP;
    return ST_ACTIVE;
  endfunction

  function automatic dvp_state_e next_period(input dvp_state_e s, input logic en);
    case (s)
      ST_VSYNC:  return (VBP_LINES > 0) ? ST_VBP : ST_ACTIVE;
      ST_VBP:    return ST_ACTIVE;
      ST_ACTIVE: return (VFP_LINES > 0) ? ST_VFP : (en ? first_state() : ST_IDLE);
      default:   return en ? first_state() : ST_IDLE;
    endcase
  endfunction

  assign eol = (h_q == H_LAST);
  assign eop = eol && (int'(v_q) == lines_of(state_q) - 1);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (state_q == ST_IDLE) begin
      h_d = '0;
      v_d = '0;
      if (enable) state_d = first_state();
    end else if (eol) begin
      h_d = '0;
      if (eop) begin
        v_d     = '0;
        state_d = next_period(state_q, enable);
      end else begin
        v_d = v_q + V_W'(1);
      end
    end else begin
      h_d = h_q + H_W'(1);
    end
  end

  assign frame_last_d = (state_d == LAST_ST) && (h_d == H_LAST) &&
                        (int'(v_d) == lines_of(LAST_ST) - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP (OV-sensor style) transmitter: RGB565 stream in, vsync/href/8-bit bytes out,
// high byte first. Holds the byte mux, low-byte latch and sticky underflow flag.
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 144,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  parameter bit VS_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_db,
  output logic        frame_done,
  output logic        underflow
);

  localparam int LINE_TOT = line_tot(H_ACTIVE, H_BLANK);
  localparam int H_W      = cnt_w(LINE_TOT);
  localparam logic [H_W-1:0] H_ACT_BYTES = H_W'(2 * H_ACTIVE);

  dvp_state_e     state_q, state_d;
  logic [H_W-1:0] h_d;
  logic           frame_last_d;

  logic       vsync_d, vsync_q;
  logic       href_d, href_q;
  logic [7:0] db_d, db_q;
  logic [7:0] lo_d, lo_q;
  logic       uf_d, uf_q;
  logic       fd_q;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .state_q     (state_q),
    .state_d     (state_d),
    .h_d         (h_d),
    .frame_last_d(frame_last_d)
  );

  // Outputs are registered from the next-cycle timing, so a pixel accepted
  // now appears as the high byte on the following cycle.
  assign pix_ready = ~rst & href_d & ~h_d[0];

  always_comb begin
    vsync_d = (state_d == ST_VSYNC) ? VS_POL : ~VS_POL;
    href_d  = (state_d == ST_ACTIVE) && (h_d < H_ACT_BYTES);
    db_d    = '0;
    lo_d    = lo_q;
    uf_d    = uf_q;
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) uf_d = 1'b0;
    if (pix_ready) begin
      db_d = pix_valid ? pix_data[15:8] : 8'h00;
      lo_d = pix_valid ? pix_data[7:0]  : 8'h00;
      if (!pix_valid) uf_d = 1'b1;
    end else if (href_d) begin
      db_d = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= ~VS_POL;
      href_q  <= 1'b0;
      db_q    <= '0;
      fd_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      db_q    <= db_d;
      fd_q    <= frame_last_d;
      uf_q    <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    lo_q <= lo_d;
  end

  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_db     = db_q;
  assign frame_done = fd_q;
  assign underflow  = uf_q;

endmodule
